// File: rtl/ctl_spi_pkg.sv
// ctl_spi_pkg: shared types and constants for the control-port SPI slave.
//   spi_state_e   : frame state (IDLE = CS high, SHIFT = CS low)
//   CRC8_POLY     : CRC-8 polynomial used by the optional receive checksum
//   IDLE_FILL_DEF : default byte sent when no response byte is available
//   crc8_byte()   : one-byte CRC-8 step (MSB first, no reflection)
package ctl_spi_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   localparam logic [7:0] CRC8_POLY     = 8'h07;
   localparam logic [7:0] IDLE_FILL_DEF = 8'hFF;

   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      return c;
   endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: registered rise/fall pulses for one slow, already-refined input.
//   clk, rst_n : system clock, synchronous active-low reset
//   d          : input level (clk domain)
//   rise, fall : one-cycle pulses, one clk after the registered edge is seen
// RST_VAL is the idle level of the input so that leaving reset never fakes an edge.
module spi_edge_detect #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_q  <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         d_q  <= d;
         rise <= d & ~d_q;
         fall <= ~d & d_q;
      end
   end

endmodule

// File: rtl/ctl_spi_slave.sv
// ctl_spi_slave: byte-level SPI slave (mode 0, MSB first) for the control port.
// SCK is handled as slow data in the clk domain; nothing here is clocked by SCK.
//   spi_sck/spi_cs/spi_si : refined SCK, refined CS (active low), raw MOSI
//   spi_so                : MISO, driven low outside a frame
//   frame_start/frame_end : pulses on CS fall / CS rise
//   rx_data/rx_valid/rx_index : received byte, update strobe, byte index in frame
//   tx_data/tx_load/tx_req    : response byte, load strobe, next-byte request
//   tx_underrun           : sticky, IDLE_FILL was sent; cleared at frame start
//   rx_crc                : CRC-8 of complete bytes in frame (CTL_SPI_RX_CRC_EN only)
// Optional feature macro: CTL_SPI_RX_CRC_EN.
module ctl_spi_slave
   import ctl_spi_pkg::*;
#(
   parameter int              BYTE_CNT_W = 8,
   parameter logic [7:0]      IDLE_FILL  = IDLE_FILL_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_sck,
   input  logic                  spi_cs,
   input  logic                  spi_si,
   output logic                  spi_so,
   output logic                  frame_start,
   output logic                  frame_end,
   output logic [7:0]            rx_data,
   output logic                  rx_valid,
   output logic [BYTE_CNT_W-1:0] rx_index,
   input  logic [7:0]            tx_data,
   input  logic                  tx_load,
   output logic                  tx_req,
   output logic                  tx_underrun
`ifdef CTL_SPI_RX_CRC_EN
   ,
   output logic [7:0]            rx_crc
`endif
);

   spi_state_e state, state_nxt;

   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic si_s1, si_s2;

   logic [7:0]            rx_shift;
   logic [2:0]            bit_cnt;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic                  byte_done;   // 8th rise seen, next SCK fall is a byte boundary
   logic [7:0]            tx_shift;
   logic [7:0]            tx_hold;
   logic                  hold_valid;

   logic       frame_go, frame_stop, sck_rise_en, sck_fall_en, byte_last, boundary;
   logic [7:0] rx_byte;

   spi_edge_detect #(.RST_VAL(1'b0)) u_sck_edge (
      .clk(clk), .rst_n(rst_n), .d(spi_sck), .rise(sck_rise), .fall(sck_fall)
   );

   spi_edge_detect #(.RST_VAL(1'b1)) u_cs_edge (
      .clk(clk), .rst_n(rst_n), .d(spi_cs), .rise(cs_rise), .fall(cs_fall)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         si_s1 <= 1'b0;
         si_s2 <= 1'b0;
      end else begin
         si_s1 <= spi_si;
         si_s2 <= si_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus the qualified events the datapath acts on.
   // A CS rise masks any SCK edge detected in the same cycle.
   always_comb begin
      state_nxt   = state;
      frame_go    = 1'b0;
      frame_stop  = 1'b0;
      sck_rise_en = 1'b0;
      sck_fall_en = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               frame_go  = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               frame_stop = 1'b1;
               state_nxt  = IDLE;
            end else begin
               sck_rise_en = sck_rise;
               sck_fall_en = sck_fall;
            end
         end
         default: state_nxt = IDLE;
      endcase
      byte_last = sck_rise_en && (bit_cnt == 3'd7);
      boundary  = frame_go || (sck_fall_en && byte_done);
      rx_byte   = {rx_shift[6:0], si_s2};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         rx_valid    <= 1'b0;
         tx_req      <= 1'b0;
         rx_data     <= '0;
         rx_index    <= '0;
         rx_shift    <= '0;
         bit_cnt     <= '0;
         byte_cnt    <= '0;
         byte_done   <= 1'b0;
         tx_shift    <= '0;
         tx_hold     <= '0;
         hold_valid  <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         frame_start <= frame_go;
         frame_end   <= frame_stop;
         rx_valid    <= byte_last;
         tx_req      <= byte_last;

         if (frame_go) begin
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            byte_done   <= 1'b0;
            tx_underrun <= 1'b0;
         end

         // Partial bits are simply abandoned; the next frame restarts bit_cnt.
         if (frame_stop) begin
            bit_cnt   <= '0;
            byte_done <= 1'b0;
         end

         if (sck_rise_en) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data   <= rx_byte;
               rx_index  <= byte_cnt;
               byte_cnt  <= byte_cnt + BYTE_CNT_W'(1);
               byte_done <= 1'b1;
            end
         end

         // Boundary: load the next response byte. A load in this very cycle
         // bypasses the holding register. The underrun set follows the
         // frame_go clear so a frame with no preload still flags byte 0.
         if (boundary) begin
            if (tx_load) begin
               tx_shift <= tx_data;
            end else if (hold_valid) begin
               tx_shift <= tx_hold;
            end else begin
               tx_shift    <= IDLE_FILL;
               tx_underrun <= 1'b1;
            end
            hold_valid <= 1'b0;
            byte_done  <= 1'b0;
         end else begin
            if (sck_fall_en)
               tx_shift <= {tx_shift[6:0], 1'b0};
            if (tx_load) begin
               tx_hold    <= tx_data;
               hold_valid <= 1'b1;
            end else if (frame_stop) begin
               hold_valid <= 1'b0;
            end
         end
      end
   end

`ifdef CTL_SPI_RX_CRC_EN
   always_ff @(posedge clk) begin
      if (!rst_n)         rx_crc <= '0;
      else if (frame_go)  rx_crc <= '0;
      else if (byte_last) rx_crc <= crc8_byte(rx_crc, rx_byte);
   end
`else
   // Receive CRC not built: no checksum state or port.
`endif

   assign spi_so = (state == SHIFT) & tx_shift[7];

endmodule

// File: tb/tb_ctl_spi_slave.sv
// tb_ctl_spi_slave: directed bench for ctl_spi_slave. A bench-side SPI master
// drives mode-0 bytes with a half period of H clk cycles; a negedge monitor logs
// received bytes and counts the one-cycle pulses. Define CTL_SPI_RX_CRC_EN to
// also exercise the receive CRC.
module tb_ctl_spi_slave;

   localparam int H = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_sck, spi_cs, spi_si, spi_so;
   logic       frame_start, frame_end, rx_valid, tx_req, tx_underrun, tx_load;
   logic [7:0] rx_data, rx_index, tx_data;
`ifdef CTL_SPI_RX_CRC_EN
   logic [7:0] rx_crc;
`endif

   int total = 0;
   int bad   = 0;

   int         rx_n = 0, fs_n = 0, fe_n = 0, rq_n = 0;
   logic [7:0] rx_log  [256];
   logic [7:0] idx_log [256];

   always #5 clk = ~clk;

   ctl_spi_slave dut (
      .clk(clk), .rst_n(rst_n),
      .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_si(spi_si), .spi_so(spi_so),
      .frame_start(frame_start), .frame_end(frame_end),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_index(rx_index),
      .tx_data(tx_data), .tx_load(tx_load), .tx_req(tx_req),
      .tx_underrun(tx_underrun)
`ifdef CTL_SPI_RX_CRC_EN
      , .rx_crc(rx_crc)
`endif
   );

   always @(negedge clk) begin
      if (rx_valid) begin
         rx_log[rx_n[7:0]]  <= rx_data;
         idx_log[rx_n[7:0]] <= rx_index;
         rx_n               <= rx_n + 1;
      end
      if (frame_start) fs_n <= fs_n + 1;
      if (frame_end)   fe_n <= fe_n + 1;
      if (tx_req)      rq_n <= rq_n + 1;
   end

   task automatic pulse_load(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      repeat (H) @(negedge clk);
   endtask

   task automatic cs_high();
      spi_cs = 1'b1;
      repeat (H) @(negedge clk);
   endtask

   // Shift nb bits of mosi (MSB first), sampling MISO just before each rise.
   // ld_mode 1: pulse tx_load in the high phase after the 8th rise (answers tx_req).
   // ld_mode 2: pulse tx_load in the exact cycle the 8th-fall boundary is acted on.
   task automatic spi_byte(input logic [7:0] mosi, input int nb, input int ld_mode,
                           input logic [7:0] ld_data, output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 7; i >= 8 - nb; i--) begin
         spi_si = mosi[i];
         repeat (H) @(negedge clk);
         miso[i] = spi_so;
         spi_sck = 1'b1;
         repeat (H) @(negedge clk);
         if (i == 0 && ld_mode == 1) pulse_load(ld_data);
         spi_sck = 1'b0;
         if (i == 0 && ld_mode == 2) begin
            @(negedge clk);
            pulse_load(ld_data);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_si = 1'b0;
      tx_load = 1'b0; tx_data = 8'h00;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (spi_so !== 1'b0)      begin bad++; $display("FAIL reset_so: got %b want 0", spi_so); end
      total++; if (rx_data !== 8'h00)    begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      total++; if (rx_index !== 8'h00)   begin bad++; $display("FAIL reset_rx_index: got %h want 00", rx_index); end
      total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", tx_underrun); end
      total++; if ({frame_start, frame_end, rx_valid, tx_req} !== 4'b0000)
         begin bad++; $display("FAIL reset_pulses: got %b want 0000", {frame_start, frame_end, rx_valid, tx_req}); end
      total++; if (fs_n !== 0)           begin bad++; $display("FAIL reset_no_frame: got %0d want 0", fs_n); end
   endtask

   task automatic test_basic();
      int fs0, fe0, rq0, r0;
      logic [7:0] m0, m1;
      fs0 = fs_n; fe0 = fe_n; rq0 = rq_n; r0 = rx_n;
      pulse_load(8'h81);
      cs_low();
      spi_byte(8'hA5, 8, 1, 8'h42, m0);
      // keep the decoder supplying so the last boundary does not underrun
      spi_byte(8'h3C, 8, 1, 8'h00, m1);
      cs_high();
      total++; if (fs_n - fs0 !== 1)     begin bad++; $display("FAIL basic_frame_start: got %0d want 1", fs_n - fs0); end
      total++; if (fe_n - fe0 !== 1)     begin bad++; $display("FAIL basic_frame_end: got %0d want 1", fe_n - fe0); end
      total++; if (rq_n - rq0 !== 2)     begin bad++; $display("FAIL basic_tx_req: got %0d want 2", rq_n - rq0); end
      total++; if (rx_n - r0 !== 2)      begin bad++; $display("FAIL basic_rx_count: got %0d want 2", rx_n - r0); end
      total++; if (rx_log[r0] !== 8'hA5) begin bad++; $display("FAIL basic_rx0: got %h want a5", rx_log[r0]); end
      total++; if (idx_log[r0] !== 8'h00) begin bad++; $display("FAIL basic_idx0: got %h want 00", idx_log[r0]); end
      total++; if (rx_log[r0+1] !== 8'h3C) begin bad++; $display("FAIL basic_rx1: got %h want 3c", rx_log[r0+1]); end
      total++; if (idx_log[r0+1] !== 8'h01) begin bad++; $display("FAIL basic_idx1: got %h want 01", idx_log[r0+1]); end
      total++; if (m0 !== 8'h81)         begin bad++; $display("FAIL basic_so0: got %h want 81", m0); end
      total++; if (m1 !== 8'h42)         begin bad++; $display("FAIL basic_so1: got %h want 42", m1); end
      total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL basic_underrun: got %b want 0", tx_underrun); end
      total++; if (spi_so !== 1'b0)      begin bad++; $display("FAIL basic_so_idle: got %b want 0", spi_so); end
   endtask

   task automatic test_underrun();
      logic [7:0] m0, m1;
      cs_low();
      spi_byte(8'h01, 8, 0, 8'h00, m0);
      spi_byte(8'h02, 8, 0, 8'h00, m1);
      cs_high();
      total++; if (m0 !== 8'hFF)         begin bad++; $display("FAIL under_so0: got %h want ff", m0); end
      total++; if (m1 !== 8'hFF)         begin bad++; $display("FAIL under_so1: got %h want ff", m1); end
      repeat (4) @(negedge clk);
      total++; if (tx_underrun !== 1'b1) begin bad++; $display("FAIL under_sticky: got %b want 1", tx_underrun); end
   endtask

   task automatic test_cs_abort();
      int fe0, rq0, r0;
      logic [7:0] m0;
      pulse_load(8'h55);
      cs_low();
      total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL abort_underrun_clr: got %b want 0", tx_underrun); end
      fe0 = fe_n; rq0 = rq_n; r0 = rx_n;
      spi_byte(8'hF0, 5, 0, 8'h00, m0);
      pulse_load(8'hAA);   // pending hold must be dropped by the CS rise
      cs_high();
      total++; if (rx_n !== r0)          begin bad++; $display("FAIL abort_no_rx: got %0d want %0d", rx_n, r0); end
      total++; if (rq_n !== rq0)         begin bad++; $display("FAIL abort_no_req: got %0d want %0d", rq_n, rq0); end
      total++; if (fe_n - fe0 !== 1)     begin bad++; $display("FAIL abort_frame_end: got %0d want 1", fe_n - fe0); end
      cs_low();
      spi_byte(8'hC3, 8, 1, 8'h00, m0);
      cs_high();
      total++; if (rx_log[r0] !== 8'hC3) begin bad++; $display("FAIL abort_rx_next: got %h want c3", rx_log[r0]); end
      total++; if (idx_log[r0] !== 8'h00) begin bad++; $display("FAIL abort_idx_next: got %h want 00", idx_log[r0]); end
      total++; if (m0 !== 8'hFF)         begin bad++; $display("FAIL abort_hold_cleared: got %h want ff", m0); end
      total++; if (tx_underrun !== 1'b1) begin bad++; $display("FAIL abort_underrun: got %b want 1", tx_underrun); end
   endtask

   task automatic test_boundary_load();
      int r0;
      logic [7:0] m0, m1;
      r0 = rx_n;
      pulse_load(8'h5A);
      cs_low();
      spi_byte(8'h11, 8, 2, 8'h77, m0);
      spi_byte(8'h22, 8, 1, 8'h00, m1);
      cs_high();
      total++; if (m0 !== 8'h5A)         begin bad++; $display("FAIL bnd_so0: got %h want 5a", m0); end
      total++; if (m1 !== 8'h77)         begin bad++; $display("FAIL bnd_so1: got %h want 77", m1); end
      total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL bnd_underrun: got %b want 0", tx_underrun); end
      total++; if (rx_log[r0+1] !== 8'h22) begin bad++; $display("FAIL bnd_rx1: got %h want 22", rx_log[r0+1]); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] m0;
      pulse_load(8'h66);
      cs_low();
      spi_byte(8'hE7, 3, 0, 8'h00, m0);
      rst_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (spi_so !== 1'b0)      begin bad++; $display("FAIL rst_so: got %b want 0", spi_so); end
      total++; if (rx_data !== 8'h00)    begin bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
      total++; if (rx_index !== 8'h00)   begin bad++; $display("FAIL rst_rx_index: got %h want 00", rx_index); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      pulse_load(8'h66);
      cs_low();
      spi_byte(8'h12, 8, 1, 8'h00, m0);
      cs_high();
      total++; if (rx_data !== 8'h12)    begin bad++; $display("FAIL rst_new_rx: got %h want 12", rx_data); end
      total++; if (rx_index !== 8'h00)   begin bad++; $display("FAIL rst_new_idx: got %h want 00", rx_index); end
      total++; if (m0 !== 8'h66)         begin bad++; $display("FAIL rst_new_so: got %h want 66", m0); end
      total++; if (tx_underrun !== 1'b0) begin bad++; $display("FAIL rst_new_underrun: got %b want 0", tx_underrun); end
   endtask

`ifdef CTL_SPI_RX_CRC_EN
   task automatic test_crc();
      logic [7:0] m0;
      pulse_load(8'h00);
      cs_low();
      total++; if (rx_crc !== 8'h00)     begin bad++; $display("FAIL crc_clear: got %h want 00", rx_crc); end
      for (int k = 0; k < 9; k++)
         spi_byte(8'h31 + 8'(k), 8, 1, 8'h00, m0);
      total++; if (rx_crc !== 8'hF4)     begin bad++; $display("FAIL crc_check: got %h want f4", rx_crc); end
      cs_high();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_cs_abort();
      test_boundary_load();
      test_reset_mid();
`ifdef CTL_SPI_RX_CRC_EN
      test_crc();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
